// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory sequencer: latches the EX/MEM access and drives the memory for
// WAIT_CYCLES cycles. Define MISALIGN_TRAP_EN to trap non-word-aligned requests.
module mem_stage_ctrl #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned ADDR_SIZE   = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 flush,
  input  logic [31:0]          addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic                 stall,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 rdata_valid,
  output logic                 dmem_en,
  output logic                 dmem_we,
  output logic [ADDR_SIZE-1:0] dmem_addr,
  output logic [WORD_SIZE-1:0] dmem_wdata,
  input  logic [WORD_SIZE-1:0] dmem_rdata,
  output logic                 misalign
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 req, aligned, start;
  logic                 en_nxt, we_nxt, rvalid_nxt, mis_nxt;
  logic [ADDR_SIZE-1:0] addr_nxt;
  logic [WORD_SIZE-1:0] wdata_nxt, rdata_nxt;
  logic                 unused_addr_bits;

  assign req = (mem_read | mem_write) & ~flush;

`ifdef MISALIGN_TRAP_EN
  assign aligned = (addr[1:0] == 2'b00);
`else
  assign aligned = 1'b1;
`endif

  assign start = req & aligned;
  assign unused_addr_bits = ^{addr[31:ADDR_SIZE+2], addr[1:0]};

  // Stall asserts combinationally as soon as an access is accepted.
  assign stall = ((state == IDLE) & start) | (state == ACCESS);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, holding by default
  always_comb begin
    en_nxt     = dmem_en;
    we_nxt     = dmem_we;
    addr_nxt   = dmem_addr;
    wdata_nxt  = dmem_wdata;
    rdata_nxt  = rdata;
    rvalid_nxt = 1'b0;
    mis_nxt    = 1'b0;
    cnt_nxt    = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          en_nxt    = 1'b1;
          we_nxt    = mem_write;
          addr_nxt  = addr[ADDR_SIZE+1:2];
          wdata_nxt = wdata;
          cnt_nxt   = CNT_LOAD;
        end
`ifdef MISALIGN_TRAP_EN
        if (req & ~aligned) mis_nxt = 1'b1;
`endif
      end
      ACCESS: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          // dmem_we still reflects the latched op; both-high requests act as stores
          if (!dmem_we) begin
            rdata_nxt  = dmem_rdata;
            rvalid_nxt = 1'b1;
          end
          en_nxt = 1'b0;
          we_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_en     <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      cnt         <= '0;
    end else begin
      dmem_en     <= en_nxt;
      dmem_we     <= we_nxt;
      dmem_addr   <= addr_nxt;
      dmem_wdata  <= wdata_nxt;
      rdata       <= rdata_nxt;
      rdata_valid <= rvalid_nxt;
      cnt         <= cnt_nxt;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= mis_nxt;
  end
`else
  logic unused_mis;
  assign unused_mis = mis_nxt;
  assign misalign   = 1'b0;
`endif

endmodule
